// File: rtl/mem_wb_if.sv
// MEM -> WB stage bus: MEM-side instruction fields in, register-file write port and status out.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 7,
  parameter int OP_W   = 5
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [OP_W-1:0]   OpCode;
  logic [REG_W-1:0]  RdWb;
  logic [DATA_W-1:0] AluResult;
  logic [DATA_W-1:0] MemResult;
  logic [REG_W-1:0]  rs_a;
  logic [REG_W-1:0]  rs_b;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              out_valid;
  logic              fwd_a_hit;
  logic              fwd_b_hit;
  logic [15:0]       retire_cnt;
  logic              illegal_op;

  modport master (
    output stall, flush, in_valid, OpCode, RdWb, AluResult, MemResult, rs_a, rs_b,
    input  rf_we, rf_waddr, rf_wdata, out_valid, fwd_a_hit, fwd_b_hit, retire_cnt, illegal_op
  );

  modport slave (
    input  stall, flush, in_valid, OpCode, RdWb, AluResult, MemResult, rs_a, rs_b,
    output rf_we, rf_waddr, rf_wdata, out_valid, fwd_a_hit, fwd_b_hit, retire_cnt, illegal_op
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: writeback select, retire counter, sticky illegal-opcode flag.
// Define WB_FORWARD_EN to enable the writeback-to-decode forwarding compare.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 7,
  parameter int OP_W   = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  mem_wb_if.slave bus
);

  logic              valid_q;
  logic              write_q;
  logic [REG_W-1:0]  waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       cnt_q;
  logic              illegal_q;

  logic [DATA_W-1:0] sel_data;
  logic              cap_write;
  logic              cap_illegal;

  always_comb begin
    sel_data    = '0;
    cap_write   = 1'b0;
    cap_illegal = 1'b0;
    case (bus.OpCode)
      OP_W'(1), OP_W'(6): begin
        sel_data  = bus.MemResult;
        cap_write = 1'b1;
      end
      OP_W'(2), OP_W'(3), OP_W'(4), OP_W'(5), OP_W'(9): begin
        sel_data  = bus.AluResult;
        cap_write = 1'b1;
      end
      OP_W'(0), OP_W'(10): ;
      default: cap_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      // Flush kills the held instruction even while everything else is stalled.
      if (bus.flush)
        valid_q <= 1'b0;
      if (!bus.stall) begin
        valid_q <= bus.in_valid & ~bus.flush;
        write_q <= cap_write;
        waddr_q <= bus.RdWb;
        wdata_q <= sel_data;
        if (valid_q && cnt_q != '1)
          cnt_q <= cnt_q + 16'd1;
        if (bus.in_valid && !bus.flush && cap_illegal)
          illegal_q <= 1'b1;
      end
    end
  end

  assign bus.rf_we      = valid_q & write_q & ~bus.stall;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.out_valid  = valid_q;
  assign bus.retire_cnt = cnt_q;
  assign bus.illegal_op = illegal_q;

`ifdef WB_FORWARD_EN
  assign bus.fwd_a_hit = bus.rf_we & (waddr_q == bus.rs_a);
  assign bus.fwd_b_hit = bus.rf_we & (waddr_q == bus.rs_b);
`else
  assign bus.fwd_a_hit = 1'b0;
  assign bus.fwd_b_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, random run against a
// reference model, asynchronous reset and retire-counter saturation sequences.
module tb_mem_wb_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 7;
  localparam int OP_W   = 5;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W)) bus ();
  mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference state: what the stage should be holding, derived from the opcode rules.
  logic        m_valid, m_write, m_ill;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  typedef struct {
    int          stall, flush, iv, op, rd;
    logic [31:0] alu, mem;
    int          ra, rb;
    int          ev, ewe, ea;
    logic [31:0] ed;
    int          ec, eill, efa, efb;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(int stall, int flush, int iv, int op, int rd,
                              logic [31:0] alu, logic [31:0] mem, int ra, int rb,
                              int ev, int ewe, int ea, logic [31:0] ed, int ec,
                              int eill, int efa, int efb);
    vec_t v;
    v.stall = stall; v.flush = flush; v.iv = iv; v.op = op; v.rd = rd;
    v.alu = alu; v.mem = mem; v.ra = ra; v.rb = rb;
    v.ev = ev; v.ewe = ewe; v.ea = ea; v.ed = ed; v.ec = ec;
    v.eill = eill; v.efa = efa; v.efb = efb;
    return v;
  endfunction

  function automatic bit is_write(int op);
    return op inside {[1:6], 9};
  endfunction

  function automatic bit is_legal(int op);
    return op inside {[0:6], 9, 10};
  endfunction

  function automatic logic [31:0] wb_value(int op, logic [31:0] alu, logic [31:0] mem);
    if (op inside {[2:5], 9}) return alu;
    if (op inside {1, 6})     return mem;
    return 32'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(int stall, int flush, int iv, int op, int rd,
                       logic [31:0] alu, logic [31:0] mem, int ra, int rb);
    bus.stall     = (stall != 0);
    bus.flush     = (flush != 0);
    bus.in_valid  = (iv != 0);
    bus.OpCode    = OP_W'(op);
    bus.RdWb      = REG_W'(rd);
    bus.AluResult = alu;
    bus.MemResult = mem;
    bus.rs_a      = REG_W'(ra);
    bus.rs_b      = REG_W'(rb);
  endtask

  task automatic mreset();
    m_valid = 1'b0; m_write = 1'b0; m_ill = 1'b0;
    m_addr = '0; m_data = '0; m_cnt = '0;
  endtask

  // Advance one clock, applying the capture rules to the model at the edge.
  task automatic tick();
    int op;
    @(posedge clk);
    op = int'(bus.OpCode);
    if (!bus.stall) begin
      if (m_valid) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      m_valid = bus.in_valid && !bus.flush;
      m_write = is_write(op);
      m_addr  = bus.RdWb;
      m_data  = wb_value(op, bus.AluResult, bus.MemResult);
      if (bus.in_valid && !bus.flush && !is_legal(op)) m_ill = 1'b1;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_model(string tag);
    logic we;
    we = m_valid & m_write & ~bus.stall;
    chk({tag, ".rf_we"},      32'(bus.rf_we),      32'(we));
    chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'(m_addr));
    chk({tag, ".rf_wdata"},   bus.rf_wdata,        m_data);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_valid));
    chk({tag, ".retire_cnt"}, 32'(bus.retire_cnt), 32'(m_cnt));
    chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'(m_ill));
    chk({tag, ".fwd_a_hit"},  32'(bus.fwd_a_hit),  32'(FWD & we & (m_addr == bus.rs_a)));
    chk({tag, ".fwd_b_hit"},  32'(bus.fwd_b_hit),  32'(FWD & we & (m_addr == bus.rs_b)));
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".rf_we"},      32'(bus.rf_we),      32'd0);
    chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'd0);
    chk({tag, ".rf_wdata"},   bus.rf_wdata,        32'd0);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
    chk({tag, ".retire_cnt"}, 32'(bus.retire_cnt), 32'd0);
    chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'd0);
    chk({tag, ".fwd_a_hit"},  32'(bus.fwd_a_hit),  32'd0);
    chk({tag, ".fwd_b_hit"},  32'(bus.fwd_b_hit),  32'd0);
  endtask

  initial begin
    // Expected columns describe what is visible during the row's cycle, before its edge.
    tbl[0]  = mk(0,0,1, 2, 5, 32'h1234, 32'h0,        0, 0,  0,0, 0, 32'h0,        0,0,0,0);
    tbl[1]  = mk(0,0,1, 6, 9, 32'h77,   32'hCAFE0001, 0, 0,  1,1, 5, 32'h1234,     0,0,0,0);
    tbl[2]  = mk(0,0,1,10, 3, 32'h88,   32'h99,       0, 0,  1,1, 9, 32'hCAFE0001, 1,0,0,0);
    tbl[3]  = mk(0,0,1, 3,12, 32'hAAAA, 32'h0,        0, 0,  1,0, 3, 32'h0,        2,0,0,0);
    tbl[4]  = mk(1,0,1, 2, 1, 32'h55,   32'h0,       12,13,  1,0,12, 32'hAAAA,     3,0,0,0);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(0,0,0, 0, 0, 32'h0,    32'h0,       12,13,  1,1,12, 32'hAAAA,     3,0,1,0);
    tbl[8]  = mk(0,0,0, 0, 0, 32'h0,    32'h0,        0, 0,  0,0, 0, 32'h0,        4,0,0,0);
    tbl[9]  = mk(0,0,1, 2, 4, 32'h11,   32'h0,        0, 0,  0,0, 0, 32'h0,        4,0,0,0);
    tbl[10] = mk(1,1,1, 9, 6, 32'h33,   32'h0,        0, 0,  1,0, 4, 32'h11,       4,0,0,0);
    tbl[11] = mk(0,1,1, 8, 7, 32'h22,   32'h0,        0, 0,  0,0, 4, 32'h11,       4,0,0,0);
    tbl[12] = mk(0,0,1, 8, 7, 32'h22,   32'h0,        0, 0,  0,0, 7, 32'h0,        4,0,0,0);
    tbl[13] = mk(0,0,0, 0, 0, 32'h0,    32'h0,        0, 0,  1,0, 7, 32'h0,        4,1,0,0);
    tbl[14] = mk(0,0,0, 0, 0, 32'h0,    32'h0,        0, 0,  0,0, 0, 32'h0,        5,1,0,0);

    drive(0,0,0,0,0,0,0,0,0);
    mreset();
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].stall, tbl[i].flush, tbl[i].iv, tbl[i].op, tbl[i].rd,
            tbl[i].alu, tbl[i].mem, tbl[i].ra, tbl[i].rb);
      #1;
      chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(tbl[i].ev));
      chk({tag, ".rf_we"},      32'(bus.rf_we),      32'(tbl[i].ewe));
      chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'(tbl[i].ea));
      chk({tag, ".rf_wdata"},   bus.rf_wdata,        tbl[i].ed);
      chk({tag, ".retire_cnt"}, 32'(bus.retire_cnt), 32'(tbl[i].ec));
      chk({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'(tbl[i].eill));
      chk({tag, ".fwd_a_hit"},  32'(bus.fwd_a_hit),  32'(FWD & (tbl[i].efa != 0)));
      chk({tag, ".fwd_b_hit"},  32'(bus.fwd_b_hit),  32'(FWD & (tbl[i].efb != 0)));
      tick();
    end

    // Randomized run against the model, starting from a fresh reset.
    rst_n = 1'b0;
    mreset();
    #1 check_model("rand_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int op, rd;
      op = ($urandom_range(0, 11) == 0) ? int'($urandom_range(11, 31)) : int'($urandom_range(0, 10));
      rd = int'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 6) == 0) ? 1 : 0,
            ($urandom_range(0, 4) != 0) ? 1 : 0, op, rd, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      #1 check_model($sformatf("rand%0d", n));
      tick();
    end

    // Reset asserted between edges with a live instruction held.
    drive(0,0,1,2,5,32'h5A5A,0,5,5);
    tick();
    drive(0,0,1,3,6,32'h6B6B,0,6,6);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    mreset();
    rst_n = 1'b1;
    drive(0,0,0,0,0,0,0,0,0);
    tick();
    #1 check_model("after_release");

    // Saturation: keep retiring until just below the top, then retire past it.
    drive(0,0,1,2,1,32'h1,0,0,0);
    while (m_cnt != 16'hFFFC) tick();
    for (int k = 0; k < 5; k++) begin
      #1 check_model($sformatf("sat%0d", k));
      tick();
    end
    chk("sat_final", 32'(bus.retire_cnt), 32'h0000FFFF);
    #1 rst_n = 1'b0;
    #1 check_all_zero("sat_reset");
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
